// File: rtl/alu_acc_sequencer.sv
// Command FIFO + accumulator sequencer driving a combinational ALU.
// Each queued command yields exactly one result on a valid/ready port.
module alu_acc_sequencer #(
    parameter int unsigned n     = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_load,
    input  logic [2:0]   cmd_op,
    input  logic [n-1:0] cmd_data,
    output logic [n-1:0] alu_a,
    output logic [n-1:0] alu_b,
    output logic [2:0]   alu_s,
    input  logic [n-1:0] alu_f,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [n-1:0] res_data,
    output logic [n-1:0] acc,
    output logic         busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned EW = n + 4;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    state_t        state;
    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          load_q;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic [EW-1:0] head;

    // Wrap bit distinguishes full from empty when the index bits match.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign cmd_ready = !full;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = !empty && ((state == IDLE) || ((state == RESP) && res_ready));
    assign head      = mem[rd_ptr[AW-1:0]];
    assign busy      = (state != IDLE) || !empty;

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {cmd_load, cmd_op, cmd_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            load_q    <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_s     <= '0;
            acc       <= '0;
            res_data  <= '0;
            res_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            // Operand registers only move on a pop, keeping the ALU inputs quiet.
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                alu_a  <= acc;
                alu_b  <= head[n-1:0];
                alu_s  <= head[n+2:n];
                load_q <= head[EW-1];
            end
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    acc       <= load_q ? alu_b : alu_f;
                    res_data  <= load_q ? alu_b : alu_f;
                    res_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= pop ? ISSUE : IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
